// File: rtl/palette_pkg.sv
// Shared types and constants for the palette arbiter: RGB entry layout,
// power-up palette contents and fade controller encoding.
package palette_pkg;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;

  localparam rgb12_t DEFAULT_PALETTE [0:15] = '{
    12'h000, 12'h00A, 12'h0A0, 12'h0AA,
    12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
    12'h555, 12'h55F, 12'h5F5, 12'h5FF,
    12'hF55, 12'hF5F, 12'hFF5, 12'hFFF
  };

  typedef enum logic [1:0] {
    F_IDLE = 2'd0,
    F_RUN  = 2'd1,
    F_DONE = 2'd2
  } fade_state_t;

  localparam logic [4:0] FADE_LEVEL_MAX = 5'd16;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or above ptr
// (wrapping at NUM_REQ) receives a one-hot grant.
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt
);

  logic found;

  // Scan offsets from ptr upward; modulo keeps non-power-of-two counts correct.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && req[i] && (i == ((int'(ptr) + k) % NUM_REQ))) begin
          gnt[i] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/palette_arbiter.sv
// Shared 12-bit RGB palette with round-robin read port and fairly interleaved
// reload writes. Define PALETTE_FADE_EN to add the brightness fade controller.
module palette_arbiter
  import palette_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
`ifdef PALETTE_FADE_EN
  , parameter logic [15:0] FADE_DIV = 16'd50000
`endif
) (
  input  logic                     Clk,
  input  logic                     Reset_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*IDX_W-1:0] index,
  output logic [NUM_REQ-1:0]       gnt,
  output logic                     rsp_valid,
  output logic [ID_W-1:0]          rsp_id,
  output logic [3:0]               red,
  output logic [3:0]               green,
  output logic [3:0]               blue,
  input  logic                     wr_en,
  input  logic [IDX_W-1:0]         wr_addr,
  input  logic [11:0]              wr_data,
  output logic                     wr_ready,
  output logic                     busy
`ifdef PALETTE_FADE_EN
  , input  logic                   fade_start
  , input  logic                   fade_dir
  , output logic                   fade_done
`endif
);

  localparam int ENTRIES = 2**IDX_W;

  logic [NUM_REQ-1:0] rr_gnt;
  logic               any_req;
  logic               wr_accept;
  logic               read_slot;
  logic [ID_W-1:0]    gnt_idx;
  logic [IDX_W-1:0]   gnt_index;

  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic               last_was_write_q, last_was_write_d;
  rgb12_t             pal_q [ENTRIES];
  rgb12_t             pal_d [ENTRIES];
  logic               rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
  rgb12_t             rsp_rgb_q, rsp_rgb_d;
  logic               busy_q, busy_d;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .req (req),
    .ptr (rr_ptr_q),
    .gnt (rr_gnt)
  );

  // A write yields its slot to a pending read right after a previous write,
  // so neither side can starve the other.
  always_comb begin
    any_req   = |req;
    wr_ready  = Reset_n && !(any_req && last_was_write_q);
    wr_accept = wr_en && wr_ready;
    read_slot = Reset_n && any_req && !wr_accept;
    gnt       = read_slot ? rr_gnt : '0;
  end

  always_comb begin
    gnt_idx   = '0;
    gnt_index = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rr_gnt[i]) begin
        gnt_idx   = ID_W'(i);
        gnt_index = index[i*IDX_W +: IDX_W];
      end
    end
  end

  always_comb begin
    pal_d = pal_q;
    if (wr_accept) begin
      pal_d[wr_addr] = rgb12_t'(wr_data);
    end
  end

  always_comb begin
    rr_ptr_d         = rr_ptr_q;
    rsp_valid_d      = read_slot;
    rsp_id_d         = rsp_id_q;
    rsp_rgb_d        = rsp_rgb_q;
    last_was_write_d = wr_accept;
    busy_d           = any_req | wr_en;
    if (read_slot) begin
      rr_ptr_d  = (gnt_idx == ID_W'(NUM_REQ-1)) ? '0 : gnt_idx + ID_W'(1);
      rsp_id_d  = gnt_idx;
      rsp_rgb_d = pal_q[gnt_index];
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        pal_q[i] <= DEFAULT_PALETTE[i[3:0]];
      end
    end else begin
      pal_q <= pal_d;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rr_ptr_q         <= '0;
      last_was_write_q <= 1'b0;
      rsp_valid_q      <= 1'b0;
      rsp_id_q         <= '0;
      rsp_rgb_q        <= '0;
      busy_q           <= 1'b0;
    end else begin
      rr_ptr_q         <= rr_ptr_d;
      last_was_write_q <= last_was_write_d;
      rsp_valid_q      <= rsp_valid_d;
      rsp_id_q         <= rsp_id_d;
      rsp_rgb_q        <= rsp_rgb_d;
      busy_q           <= busy_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign busy      = busy_q;

`ifdef PALETTE_FADE_EN
  fade_state_t fstate_q, fstate_d;
  logic        fdir_q, fdir_d;
  logic [4:0]  level_q, level_d;
  logic [15:0] div_q, div_d;

  function automatic logic [3:0] scale(input logic [3:0] c, input logic [4:0] lvl);
    logic [7:0] p;
    p = 8'(c) * 8'(lvl);
    return 4'(p >> 4);
  endfunction

  // fade_start while running restarts the divider from the current level.
  always_comb begin
    fstate_d = fstate_q;
    fdir_d   = fdir_q;
    level_d  = level_q;
    div_d    = div_q;
    case (fstate_q)
      F_IDLE: begin
        if (fade_start) begin
          fstate_d = F_RUN;
          fdir_d   = fade_dir;
          div_d    = '0;
        end
      end
      F_RUN: begin
        if (fade_start) begin
          fdir_d = fade_dir;
          div_d  = '0;
        end else if (div_q >= FADE_DIV - 16'd1) begin
          div_d = '0;
          if (fdir_q && level_q != 5'd0) begin
            level_d = level_q - 5'd1;
          end else if (!fdir_q && level_q != FADE_LEVEL_MAX) begin
            level_d = level_q + 5'd1;
          end
          if (level_d == (fdir_q ? 5'd0 : FADE_LEVEL_MAX)) begin
            fstate_d = F_DONE;
          end
        end else begin
          div_d = div_q + 16'd1;
        end
      end
      F_DONE:  fstate_d = F_IDLE;
      default: fstate_d = F_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      fstate_q <= F_IDLE;
      fdir_q   <= 1'b0;
      level_q  <= FADE_LEVEL_MAX;
      div_q    <= '0;
    end else begin
      fstate_q <= fstate_d;
      fdir_q   <= fdir_d;
      level_q  <= level_d;
      div_q    <= div_d;
    end
  end

  assign fade_done = (fstate_q == F_DONE);
  assign red       = scale(rsp_rgb_q.r, level_q);
  assign green     = scale(rsp_rgb_q.g, level_q);
  assign blue      = scale(rsp_rgb_q.b, level_q);
`else
  assign red   = rsp_rgb_q.r;
  assign green = rsp_rgb_q.g;
  assign blue  = rsp_rgb_q.b;
`endif

endmodule

// File: tb/tb_palette_arbiter.sv
// Randomized self-checking bench for palette_arbiter (default build) against
// a transaction-level model of the palette and arbitration rules.
module tb_palette_arbiter;

  localparam int NUM_REQ = 3;
  localparam int IDX_W   = 4;
  localparam int ID_W    = 2;

  logic                     Clk = 1'b0;
  logic                     Reset_n;
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*IDX_W-1:0] index;
  logic [NUM_REQ-1:0]       gnt;
  logic                     rsp_valid;
  logic [ID_W-1:0]          rsp_id;
  logic [3:0]               red, green, blue;
  logic                     wr_en;
  logic [IDX_W-1:0]         wr_addr;
  logic [11:0]              wr_data;
  logic                     wr_ready;
  logic                     busy;

  palette_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W), .ID_W(ID_W)) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .req       (req),
    .index     (index),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .red       (red),
    .green     (green),
    .blue      (blue),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .busy      (busy)
  );

  always #5 Clk = ~Clk;

  logic [11:0] def_pal [16] = '{
    12'h000, 12'h00A, 12'h0A0, 12'h0AA, 12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
    12'h555, 12'h55F, 12'h5F5, 12'h5FF, 12'hF55, 12'hF5F, 12'hFF5, 12'hFFF
  };

  int n_checks = 0;
  int n_errors = 0;

  // Reference state
  logic [11:0] m_pal [16];
  int          m_ptr;
  bit          m_lww;
  bit          m_vld;
  int          m_id;
  logic [11:0] m_col;
  bit          m_busy;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pal  = def_pal;
    m_ptr  = 0;
    m_lww  = 1'b0;
    m_vld  = 1'b0;
    m_id   = 0;
    m_col  = 12'h000;
    m_busy = 1'b0;
  endtask

  // Entered just after a rising edge with inputs already driven.
  task automatic run_cycle();
    int          win;
    bit          any, wwin, rd;
    logic [2:0]  eg;
    #3;
    any  = (req != 0);
    wwin = wr_en && !(any && m_lww);
    rd   = any && !wwin;
    win  = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      int j;
      j = (m_ptr + k) % NUM_REQ;
      if (req[j]) win = j;
    end
    eg = rd ? 3'(1 << win) : 3'b000;
    check("gnt", gnt, eg);
    check("wr_ready", wr_ready, !(any && m_lww));
    if (wwin) m_pal[wr_addr] = wr_data;
    if (rd) begin
      m_col = m_pal[index[win*IDX_W +: IDX_W]];
      m_id  = win;
      m_ptr = (win + 1) % NUM_REQ;
    end
    m_vld  = rd;
    m_lww  = wwin;
    m_busy = any || wr_en;
    @(posedge Clk);
    #1;
    check("rsp_valid", rsp_valid, m_vld);
    check("rsp_id", rsp_id, m_id);
    check("rgb", {red, green, blue}, m_col);
    check("busy", busy, m_busy);
  endtask

  task automatic do_reset();
    Reset_n = 1'b0;
    req     = '0;
    wr_en   = 1'b0;
    model_reset();
    #1;
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;
  endtask

  initial begin
    Reset_n = 1'b1;
    req     = 3'b111;
    wr_en   = 1'b1;
    index   = '0;
    wr_addr = '0;
    wr_data = '0;
    model_reset();
    #1;
    Reset_n = 1'b0;
    @(posedge Clk);
    @(posedge Clk);
    #1;
    check("rst_gnt", gnt, 3'b000);
    check("rst_wr_ready", wr_ready, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_rgb", {red, green, blue}, 12'h000);
    check("rst_busy", busy, 1'b0);
    req     = '0;
    wr_en   = 1'b0;
    Reset_n = 1'b1;

    // Single requester lookup
    req = 3'b001;
    index[3:0] = 4'h6;
    run_cycle();
    check("tp1_rgb", {red, green, blue}, 12'hA50);
    req = '0;
    run_cycle();

    // Fairness across all three requesters from ptr 0
    do_reset();
    req   = 3'b111;
    index = 12'h321;
    for (int k = 0; k < 6; k++) begin
      run_cycle();
      check("rr_id_seq", rsp_id, k % 3);
    end
    req = '0;
    run_cycle();

    // Write and read contending for the slot
    wr_en      = 1'b1;
    wr_addr    = 4'h3;
    wr_data    = 12'hF0F;
    req        = 3'b010;
    index[7:4] = 4'h3;
    run_cycle();
    run_cycle();
    check("wr_then_rd_rgb", {red, green, blue}, 12'hF0F);
    wr_en = 1'b0;
    req   = '0;
    run_cycle();

    // Write-only burst, then read back
    for (int k = 0; k < 4; k++) begin
      wr_en   = 1'b1;
      wr_addr = IDX_W'(8 + k);
      wr_data = 12'(12'h1A3 * (k + 1));
      run_cycle();
    end
    wr_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      req          = 3'b100;
      index[11:8]  = IDX_W'(8 + k);
      run_cycle();
      check("burst_readback", {red, green, blue}, 12'(12'h1A3 * (k + 1)));
    end
    req = '0;
    run_cycle();

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      req     = 3'($urandom_range(0, 7));
      index   = 12'($urandom);
      wr_en   = ($urandom_range(0, 2) == 0);
      wr_addr = 4'($urandom);
      wr_data = 12'($urandom);
      run_cycle();
    end
    req   = '0;
    wr_en = 1'b0;
    run_cycle();

    // Reset in the middle of a response and after a palette write
    wr_en   = 1'b1;
    wr_addr = 4'h5;
    wr_data = 12'hABC;
    run_cycle();
    wr_en      = 1'b0;
    req        = 3'b001;
    index[3:0] = 4'h5;
    run_cycle();
    check("pre_rst_rgb", {red, green, blue}, 12'hABC);
    Reset_n = 1'b0;
    #1;
    check("mid_rst_vld", rsp_valid, 1'b0);
    check("mid_rst_rgb", {red, green, blue}, 12'h000);
    model_reset();
    req = '0;
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    req        = 3'b001;
    index[3:0] = 4'h5;
    run_cycle();
    check("post_rst_default", {red, green, blue}, 12'hA0A);
    req = '0;
    run_cycle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
